// File: rtl/mfp_mem_fifo_ctrl.sv
// rtl/mfp_mem_fifo_ctrl.sv - valid/ready FIFO sequencer around an external registered-read dual-port RAM
//
// Purpose: owns the write/read pointers of a simple dual-port RAM with 1-cycle
// registered read. It prefetches entries ahead of demand and absorbs the read
// latency in a 2-entry skid buffer, so the consumer can pop every cycle.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   clear                      synchronous flush, overrides push/pop
//   wr_valid/wr_data/wr_ready  producer side, push = wr_valid & wr_ready
//   rd_valid/rd_data/rd_ready  consumer side, pop = rd_valid & rd_ready
//   level                      entries held (RAM + in flight + skid)
//   mem_write_*                RAM write port (addr = wptr, en = push)
//   mem_read_addr/data         RAM read port (addr = rptr, data one cycle later)
module mfp_mem_fifo_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH+1:0] level,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   mem_count;
    logic [ADDR_WIDTH:0]   mem_count_next;
    logic                  inflight;
    logic                  wr_ready_q;
    logic [1:0]            skid_count;
    logic [DATA_WIDTH-1:0] skid0;
    logic [DATA_WIDTH-1:0] skid1;
    logic [1:0]            skid_count_next;
    logic [DATA_WIDTH-1:0] skid0_next;
    logic [DATA_WIDTH-1:0] skid1_next;
    logic                  push;
    logic                  pop;
    logic                  fetch;
    logic [2:0]            skid_demand;

    assign wr_ready = wr_ready_q;
    assign rd_valid = (skid_count != 2'd0);
    assign rd_data  = skid0;

    // A handshake coinciding with clear is dropped.
    assign push = wr_valid & wr_ready_q & ~clear;
    assign pop  = rd_valid & rd_ready & ~clear;

    // Skid slots still needed after this cycle: current entries plus the one
    // landing from RAM, minus the one leaving. Only fetch when a slot will be free.
    assign skid_demand = {1'b0, skid_count} + {2'b00, inflight} - {2'b00, pop};
    // Uses mem_count before this cycle's push, so fetch never reads the slot being written.
    assign fetch = (|mem_count) & ~clear & (skid_demand < 3'd2);

    assign mem_write_addr = wptr;
    assign mem_write_data = wr_data;
    assign mem_write_en   = push;
    assign mem_read_addr  = rptr;

    assign level = {1'b0, mem_count}
                 + {{(ADDR_WIDTH+1){1'b0}}, inflight}
                 + {{ADDR_WIDTH{1'b0}}, skid_count};

    always_comb begin
        mem_count_next = mem_count;
        if (clear) begin
            mem_count_next = '0;
        end else begin
            mem_count_next = mem_count
                           + {{ADDR_WIDTH{1'b0}}, push}
                           - {{ADDR_WIDTH{1'b0}}, fetch};
        end
    end

    // Pop shifts the head out first, then the arriving RAM word joins the tail.
    always_comb begin
        skid0_next      = skid0;
        skid1_next      = skid1;
        skid_count_next = skid_count;
        if (pop) begin
            skid0_next      = skid1;
            skid_count_next = skid_count - 2'd1;
        end
        if (inflight) begin
            if (skid_count_next == 2'd0) begin
                skid0_next = mem_read_data;
            end else begin
                skid1_next = mem_read_data;
            end
            skid_count_next = skid_count_next + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            mem_count  <= '0;
            inflight   <= 1'b0;
            wr_ready_q <= 1'b0;
            skid_count <= 2'd0;
            skid0      <= '0;
            skid1      <= '0;
        end else begin
            // Full only when the RAM itself holds DEPTH entries (top bit set);
            // a flush zeroes mem_count_next, so wr_ready reopens right after clear.
            wr_ready_q <= ~mem_count_next[ADDR_WIDTH];
            mem_count  <= mem_count_next;
            if (clear) begin
                wptr       <= '0;
                rptr       <= '0;
                inflight   <= 1'b0;
                skid_count <= 2'd0;
                skid0      <= '0;
                skid1      <= '0;
            end else begin
                if (push) begin
                    wptr <= wptr + 1'b1;
                end
                if (fetch) begin
                    rptr <= rptr + 1'b1;
                end
                inflight   <= fetch;
                skid_count <= skid_count_next;
                skid0      <= skid0_next;
                skid1      <= skid1_next;
            end
        end
    end

endmodule

// File: tb/tb_mfp_mem_fifo_ctrl.sv
// tb/tb_mfp_mem_fifo_ctrl.sv - scoreboard testbench for mfp_mem_fifo_ctrl
`timescale 1ns/1ps
module tb_mfp_mem_fifo_ctrl;

    localparam int AW = 2;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready;
    logic [AW+1:0] level;
    logic [AW-1:0] mem_write_addr;
    logic [DW-1:0] mem_write_data;
    logic          mem_write_en;
    logic [AW-1:0] mem_read_addr;
    logic [DW-1:0] mem_read_data;

    logic [DW-1:0] ram [1<<AW];

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_q[$];
    int            model_level = 0;
    logic          prev_stall  = 1'b0;
    logic [DW-1:0] prev_data   = '0;

    always #5 clk = ~clk;

    mfp_mem_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (clear),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_ready      (rd_ready),
        .level         (level),
        .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data),
        .mem_write_en  (mem_write_en),
        .mem_read_addr (mem_read_addr),
        .mem_read_data (mem_read_data)
    );

    always @(posedge clk) begin
        if (mem_write_en) ram[mem_write_addr] <= mem_write_data;
        mem_read_data <= ram[mem_read_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sees the values that will be handshaken on the coming rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            model_level = 0;
            prev_stall  = 1'b0;
        end else begin
            check("level", int'(level), model_level);
            if (prev_stall && rd_valid) check("rd_data_stable", int'(rd_data), int'(prev_data));
            if (clear) begin
                exp_q.delete();
                model_level = 0;
                prev_stall  = 1'b0;
            end else begin
                if (rd_valid && rd_ready) begin
                    if (exp_q.size() == 0) begin
                        check("pop_on_empty_model", 1, 0);
                    end else begin
                        check("rd_data", int'(rd_data), int'(exp_q.pop_front()));
                        model_level--;
                    end
                end
                if (wr_valid && wr_ready) begin
                    exp_q.push_back(wr_data);
                    model_level++;
                end
                prev_stall = rd_valid && !rd_ready;
                prev_data  = rd_data;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done = 0;
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (level == '0 && !rd_valid) done = 1;
            next_cycle();
        end
        check("drain_done", int'(done), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int n_acc;
        int first_block;
        bit seen;

        rst_n = 1'b0; clear = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

        // Test 1: reset state, single push latency
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wr_ready", int'(wr_ready), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_level", int'(level), 0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("wr_ready_before_edge", int'(wr_ready), 0);
        next_cycle();
        wr_valid = 1'b1; wr_data = 8'hA5; rd_ready = 1'b1;
        @(negedge clk);
        check("wr_ready_after_release", int'(wr_ready), 1);
        next_cycle();
        wr_valid = 1'b0;
        @(negedge clk);
        check("t1_c1_rd_valid", int'(rd_valid), 0);
        next_cycle();
        @(negedge clk);
        check("t1_c2_rd_valid", int'(rd_valid), 0);
        next_cycle();
        @(negedge clk);
        check("t1_c3_rd_valid", int'(rd_valid), 1);
        check("t1_c3_rd_data", int'(rd_data), 8'hA5);
        check("t1_c3_level", int'(level), 1);
        next_cycle();
        @(negedge clk);
        check("t1_c4_level", int'(level), 0);
        check("t1_c4_rd_valid", int'(rd_valid), 0);
        next_cycle();

        // Test 2: fill with rd_ready low
        rd_ready = 1'b0;
        d = 0; n_acc = 0; first_block = -1;
        for (int k = 0; k < 14; k++) begin
            wr_valid = 1'b1;
            wr_data  = DW'(d);
            @(negedge clk);
            seen = wr_ready;
            if (seen) n_acc++;
            if (!seen && first_block < 0) first_block = k;
            next_cycle();
            if (seen) d++;
        end
        wr_valid = 1'b0;
        check("t2_accepted", n_acc, 6);
        check("t2_first_block", first_block, 6);
        @(negedge clk);
        check("t2_level", int'(level), 6);
        check("t2_wr_ready", int'(wr_ready), 0);
        next_cycle();
        drain();

        // Test 3: streaming with pointer wrap
        rd_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            wr_valid = 1'b1;
            wr_data  = DW'(8'h40 + k);
            @(negedge clk);
            if (k == 3 || k == 20 || k == 39) begin
                check("t3_rd_valid", int'(rd_valid), 1);
                check("t3_level", int'(level), 3);
                check("t3_wr_ready", int'(wr_ready), 1);
            end
            next_cycle();
        end
        drain();

        // Test 4: random handshakes
        for (int k = 0; k < 10000; k++) begin
            wr_valid = 1'($urandom_range(0, 1));
            rd_ready = 1'($urandom_range(0, 1));
            wr_data  = DW'($urandom_range(0, 255));
            next_cycle();
        end
        drain();

        // Test 5: clear while a fetch is in flight
        rd_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wr_valid = 1'b1;
            wr_data  = DW'(8'h11 * (k + 1));
            next_cycle();
        end
        clear = 1'b1; wr_valid = 1'b1; wr_data = 8'h77; rd_ready = 1'b1;
        @(negedge clk);
        check("t5_level_before_clear", int'(level), 3);
        next_cycle();
        clear = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        check("t5_level_after_clear", int'(level), 0);
        check("t5_rd_valid_after_clear", int'(rd_valid), 0);
        next_cycle();
        wr_valid = 1'b1; wr_data = 8'h3C; seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            seen = wr_ready;
            next_cycle();
        end
        wr_valid = 1'b0;
        check("t5_push_accepted", int'(seen), 1);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (rd_valid) begin
                seen = 1;
                check("t5_first_pop", int'(rd_data), 8'h3C);
            end
            next_cycle();
        end
        check("t5_rd_valid_seen", int'(seen), 1);
        drain();

        // Test 6: asynchronous reset mid-stream
        rd_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wr_valid = 1'b1;
            wr_data  = DW'(8'hC0 + k);
            next_cycle();
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rd_valid_async", int'(rd_valid), 0);
        check("t6_wr_ready_async", int'(wr_ready), 0);
        check("t6_level_async", int'(level), 0);
        check("t6_mem_write_en", int'(mem_write_en), 0);
        #9;
        rst_n = 1'b1;
        #1;
        check("t6_wr_ready_released", int'(wr_ready), 0);
        wr_valid = 1'b0;
        next_cycle();
        check("t6_wr_ready_edge", int'(wr_ready), 1);
        check("t6_level_edge", int'(level), 0);
        check("t6_rd_valid_edge", int'(rd_valid), 0);
        for (int k = 0; k < 6; k++) begin
            wr_valid = 1'b1;
            wr_data  = DW'(8'hD0 + k);
            next_cycle();
        end
        drain();
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
